// File: rtl/udma_i2s_rx_arbiter.sv
// Round-robin merge of NUM_CHANNELS non-stallable sample sources into one
// registered valid/ready stream, with a one-entry holding buffer per source.
module udma_i2s_rx_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int CNT_WIDTH    = 16,
    localparam int CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   rstn_i,
    input  logic                                   cfg_en_i,
    input  logic                                   cfg_clr_i,
    input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] ch_data_i,
    input  logic [NUM_CHANNELS-1:0]                ch_valid_i,
    output logic [DATA_WIDTH-1:0]                  rx_data_o,
    output logic [CH_W-1:0]                        rx_ch_o,
    output logic                                   rx_valid_o,
    input  logic                                   rx_ready_i,
    output logic [NUM_CHANNELS-1:0]                ovf_o,
    output logic [CNT_WIDTH-1:0]                   drop_cnt_o
);

    // Handshake: a word transfers on any cycle with rx_valid_o=1 and
    // rx_ready_i=1; while valid and not ready, data and channel stay stable.

    logic [NUM_CHANNELS-1:0]                 sbuf_vld_q, sbuf_vld_d;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] sbuf_data_q, sbuf_data_d;
    logic [CH_W-1:0]                         ptr_q, ptr_d;
    logic                                    rx_valid_q, rx_valid_d;
    logic [DATA_WIDTH-1:0]                   rx_data_q, rx_data_d;
    logic [CH_W-1:0]                         rx_ch_q, rx_ch_d;
    logic [NUM_CHANNELS-1:0]                 ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0]                    cnt_q, cnt_d;

    logic                ld;
    logic                found;
    logic                gnt_vld;
    logic [CH_W-1:0]     gnt_idx;
    logic [CH_W:0]       drop_num;
    logic [CNT_WIDTH:0]  cnt_sum;
    int                  c;

    always_comb begin
        sbuf_vld_d  = sbuf_vld_q;
        sbuf_data_d = sbuf_data_q;
        ptr_d       = ptr_q;
        rx_valid_d  = rx_valid_q;
        rx_data_d   = rx_data_q;
        rx_ch_d     = rx_ch_q;
        ovf_d       = '0;
        drop_num    = '0;
        found       = 1'b0;
        gnt_idx     = '0;
        c           = 0;

        ld = ~rx_valid_q | rx_ready_i;

        // Search starts just after the last grant so every source gets a turn.
        for (int k = 1; k <= NUM_CHANNELS; k++) begin
            c = (int'(ptr_q) + k) % NUM_CHANNELS;
            if (!found && sbuf_vld_q[c]) begin
                found   = 1'b1;
                gnt_idx = CH_W'(c);
            end
        end
        gnt_vld = ld & found;

        if (ld) begin
            if (gnt_vld) begin
                rx_valid_d           = 1'b1;
                rx_data_d            = sbuf_data_q[gnt_idx];
                rx_ch_d              = gnt_idx;
                ptr_d                = gnt_idx;
                sbuf_vld_d[gnt_idx]  = 1'b0;
            end else begin
                rx_valid_d = 1'b0;
            end
        end

        // A buffer being drained this cycle can accept a new sample without loss.
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (cfg_en_i && ch_valid_i[i]) begin
                if (!sbuf_vld_q[i] || (gnt_vld && (gnt_idx == CH_W'(i)))) begin
                    sbuf_vld_d[i]  = 1'b1;
                    sbuf_data_d[i] = ch_data_i[i];
                end else begin
                    ovf_d[i] = 1'b1;
                    drop_num = drop_num + (CH_W+1)'(1);
                end
            end
        end

        cnt_sum = {1'b0, cnt_q} + (CNT_WIDTH+1)'(drop_num);
        cnt_d   = cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : cnt_sum[CNT_WIDTH-1:0];

        if (cfg_clr_i) begin
            sbuf_vld_d = '0;
            rx_valid_d = 1'b0;
            ptr_d      = CH_W'(NUM_CHANNELS - 1);
            cnt_d      = '0;
            ovf_d      = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sbuf_vld_q  <= '0;
            sbuf_data_q <= '0;
            ptr_q       <= CH_W'(NUM_CHANNELS - 1);
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_ch_q     <= '0;
            ovf_q       <= '0;
            cnt_q       <= '0;
        end else begin
            sbuf_vld_q  <= sbuf_vld_d;
            sbuf_data_q <= sbuf_data_d;
            ptr_q       <= ptr_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            rx_ch_q     <= rx_ch_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rx_data_o  = rx_data_q;
    assign rx_ch_o    = rx_ch_q;
    assign rx_valid_o = rx_valid_q;
    assign ovf_o      = ovf_q;
    assign drop_cnt_o = cnt_q;

endmodule
